// File: rtl/multiplier_arbiter.sv
// Two-requester arbiter in front of a shared combinational 4x4 multiplier.
// One operation in flight; ties go to the requester that was not served last.
//
// state | meaning
// IDLE  | arbitrating, may accept one request
// MUL   | operands presented to the multiplier, product captured on exit
// RESP  | result held on rsp_* until the consumer takes it
module multiplier_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_A,
  input  logic [3:0] req0_B,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_A,
  input  logic [3:0] req1_B,
  output logic       req1_ready,
  output logic [3:0] mul_A,
  output logic [3:0] mul_B,
  input  logic [7:0] mul_Product,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_Product,
  input  logic       rsp_ready,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] mul_a_q, mul_a_d;
  logic [3:0] mul_b_q, mul_b_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_product_q, rsp_product_d;
  logic [7:0] op_count_q, op_count_d;
  logic       last_grant_q, last_grant_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       busy_q, busy_d;

  logic       grant_vld;
  logic       grant_id;
  logic       rsp_fire;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld && grant_id;
  assign rsp_fire   = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d       = state_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    op_count_d    = op_count_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d      = MUL;
          mul_a_d      = grant_id ? req1_A : req0_A;
          mul_b_d      = grant_id ? req1_B : req0_B;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
        end
      end
      MUL: begin
        state_d       = RESP;
        rsp_product_d = mul_Product;
      end
      RESP: begin
        if (rsp_fire) begin
          state_d    = IDLE;
          op_count_d = op_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with state_q.
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mul_a_q       <= 4'd0;
      mul_b_q       <= 4'd0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= 8'd0;
      op_count_q    <= 8'd0;
      last_grant_q  <= 1'b1;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      op_count_q    <= op_count_d;
      last_grant_q  <= last_grant_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign mul_A       = mul_a_q;
  assign mul_B       = mul_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_Product = rsp_product_q;
  assign busy        = busy_q;
  assign op_count    = op_count_q;

endmodule
